// File: rtl/cpu_mux_pkg.sv
// Shared types for the datapath N:1 registered selector.
// Skid-buffer occupancy states and select-width helper.
package cpu_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  function automatic int sel_w_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N_CH:1 channel select.
// Out-of-range selects yield zero and raise err_o.
module mux_n_sel
  import cpu_mux_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int N_CH   = 4,
  parameter int SEL_W  = sel_w_f(N_CH)
) (
  input  logic [N_CH*ADDR_W-1:0] data_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [ADDR_W-1:0]      val_o,
  output logic                   err_o
);

  always_comb begin
    val_o = '0;
    err_o = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_i == SEL_W'(k)) begin
        val_o = data_i[k*ADDR_W +: ADDR_W];
        err_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N:1 selector with valid/ready handshake,
// 2-entry skid buffer, flush and sticky select-error flag.
module mux_n_pipe
  import cpu_mux_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int N_CH   = 4,
  parameter int SEL_W  = sel_w_f(N_CH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_CH*ADDR_W-1:0] i_data,
  input  logic [SEL_W-1:0]       i_sel,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_flush,
  output logic [ADDR_W-1:0]      o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_sel_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] skid_q, skid_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] sel_val;
  logic              sel_err;
  logic              accept;
  logic              emit;

  mux_n_sel #(
    .ADDR_W (ADDR_W),
    .N_CH   (N_CH),
    .SEL_W  (SEL_W)
  ) u_sel (
    .data_i (i_data),
    .sel_i  (i_sel),
    .val_o  (sel_val),
    .err_o  (sel_err)
  );

  // Handshake outputs come only from registered state.
  assign o_valid   = (state_q != EMPTY);
  assign o_ready   = (state_q != TWO);
  assign o_data    = data_q;
  assign o_sel_err = err_q;

  assign accept = i_valid & o_ready;
  assign emit   = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    err_d   = err_q | (accept & sel_err);
    if (i_flush) begin
      state_d = EMPTY;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            data_d  = sel_val;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({accept, emit})
            2'b11: data_d = sel_val;
            2'b01: state_d = EMPTY;
            2'b10: begin
              skid_d  = sel_val;
              state_d = TWO;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (emit) begin
            data_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench for mux_n_pipe: vector table,
// scoreboard on the 4-channel instance, 3-channel error path.
module tb_mux_n_pipe;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4*W-1:0] a_data;
  logic [1:0]     a_sel;
  logic           a_valid, a_ready, a_flush;
  logic           a_o_ready, a_o_valid, a_o_err;
  logic [W-1:0]   a_o_data;

  logic [3*W-1:0] b_data;
  logic [1:0]     b_sel;
  logic           b_valid, b_ready, b_flush;
  logic           b_o_ready, b_o_valid, b_o_err;
  logic [W-1:0]   b_o_data;

  mux_n_pipe #(.ADDR_W(W), .N_CH(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(a_data), .i_sel(a_sel),
    .i_valid(a_valid), .o_ready(a_o_ready),
    .i_flush(a_flush), .o_data(a_o_data),
    .o_valid(a_o_valid), .i_ready(a_ready),
    .o_sel_err(a_o_err)
  );

  mux_n_pipe #(.ADDR_W(W), .N_CH(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_data(b_data), .i_sel(b_sel),
    .i_valid(b_valid), .o_ready(b_o_ready),
    .i_flush(b_flush), .o_data(b_o_data),
    .o_valid(b_o_valid), .i_ready(b_ready),
    .o_sel_err(b_o_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ca(input int k);
    return 64'hDEAD_BEEF_0000_0000 + 64'(k);
  endfunction

  function automatic logic [W-1:0] cb(input int k);
    return 64'hB0B0_0000_0000_0000 + 64'(k);
  endfunction

  // Scoreboard for instance A: queue length is the occupancy.
  logic [W-1:0] sbq[$];
  int   mq;
  logic macc, memt;

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      mq = sbq.size();
      chk("sb_valid", W'(a_o_valid), W'(mq != 0));
      chk("sb_ready", W'(a_o_ready), W'(mq != 2));
      macc = a_valid && (mq != 2);
      memt = (mq != 0) && a_ready;
      if (a_flush) begin
        sbq.delete();
      end else begin
        if (memt) begin
          chk("sb_data", a_o_data, sbq[0]);
          void'(sbq.pop_front());
        end
        if (macc) sbq.push_back(a_data[a_sel*W +: W]);
      end
    end
  end

  typedef struct {
    logic [1:0]   sel;
    logic         valid;
    logic         ready;
    logic         exp_valid;
    logic         exp_ready;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b1, ca(0)};
    tbl[1] = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b1, ca(1)};
    tbl[2] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b1, ca(2)};
    tbl[3] = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b1, ca(3)};
    tbl[4] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, ca(3)};
    tbl[5] = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b1, ca(0)};
    tbl[6] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, ca(0)};
    tbl[7] = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b0, ca(0)};
    tbl[8] = '{2'd3, 1'b0, 1'b1, 1'b1, 1'b1, ca(1)};
    tbl[9] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, ca(1)};

    a_data = {ca(3), ca(2), ca(1), ca(0)};
    b_data = {cb(2), cb(1), cb(0)};
    a_sel = 2'd0; a_valid = 1'b0;
    a_ready = 1'b1; a_flush = 1'b0;
    b_sel = 2'd0; b_valid = 1'b0;
    b_ready = 1'b1; b_flush = 1'b0;

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_valid", W'(a_o_valid), '0);
    chk("rst_data", a_o_data, '0);
    chk("rst_ready", W'(a_o_ready), W'(1));
    chk("rst_err_b", W'(b_o_err), '0);

    a_sel = 2'd2; a_valid = 1'b1;
    step();
    chk("single_valid", W'(a_o_valid), W'(1));
    chk("single_data", a_o_data, 64'hDEAD_BEEF_0000_0002);
    a_valid = 1'b0;
    step();
    chk("single_drain", W'(a_o_valid), '0);

    for (int i = 0; i < 10; i++) begin
      a_sel = tbl[i].sel;
      a_valid = tbl[i].valid;
      a_ready = tbl[i].ready;
      step();
      chk($sformatf("vec%0d_valid", i), W'(a_o_valid), W'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_ready", i), W'(a_o_ready), W'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_data", i), a_o_data, tbl[i].exp_data);
    end

    // Flush while full, with a competing accept.
    a_ready = 1'b0; a_valid = 1'b1; a_sel = 2'd0;
    step();
    a_sel = 2'd1;
    step();
    chk("fl_full", W'(a_o_ready), '0);
    a_sel = 2'd3; a_flush = 1'b1;
    step();
    a_flush = 1'b0; a_valid = 1'b0;
    chk("fl_valid", W'(a_o_valid), '0);
    chk("fl_ready", W'(a_o_ready), W'(1));
    chk("fl_err", W'(a_o_err), '0);
    a_ready = 1'b1;
    step();
    chk("fl_noleak", W'(a_o_valid), '0);
    a_valid = 1'b1; a_sel = 2'd2;
    step();
    chk("fl_after", a_o_data, ca(2));
    a_valid = 1'b0;
    step();

    // Asynchronous reset while full.
    a_ready = 1'b0; a_valid = 1'b1; a_sel = 2'd1;
    step();
    a_sel = 2'd3;
    step();
    a_valid = 1'b0;
    chk("ar_full", W'(a_o_ready), '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", W'(a_o_valid), '0);
    chk("ar_data", a_o_data, '0);
    chk("ar_ready", W'(a_o_ready), W'(1));
    step();
    step();
    rst_n = 1'b1;
    step();
    a_ready = 1'b1; a_valid = 1'b1; a_sel = 2'd2;
    step();
    chk("ar_single_valid", W'(a_o_valid), W'(1));
    chk("ar_single_data", a_o_data, ca(2));
    a_valid = 1'b0;
    step();
    chk("ar_single_drain", W'(a_o_valid), '0);

    // Out-of-range select on the 3-channel instance.
    b_valid = 1'b1; b_sel = 2'd3;
    step();
    chk("oor_valid", W'(b_o_valid), W'(1));
    chk("oor_data", b_o_data, '0);
    chk("oor_err", W'(b_o_err), W'(1));
    b_sel = 2'd1;
    step();
    chk("oor_next_data", b_o_data, cb(1));
    chk("oor_sticky", W'(b_o_err), W'(1));
    b_valid = 1'b0;
    step();
    chk("oor_idle_err", W'(b_o_err), W'(1));
    b_flush = 1'b1;
    step();
    chk("oor_flush_err", W'(b_o_err), '0);
    b_valid = 1'b1; b_sel = 2'd3;
    step();
    b_flush = 1'b0; b_valid = 1'b0;
    chk("oor_flush_acc", W'(b_o_err), '0);
    chk("oor_flush_vld", W'(b_o_valid), '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
